data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the core's data-memory interface. It accepts the core's data_memory_read/data_memory_write strobes with a byte address and write data. It stores words in an internal array, inserts a configurable number of wait states, and returns read data with a one-cycle completion pulse. It replaces the zero-wait combinational data path between the execute stage and data memory so that multi-cycle memory timing can be modelled and tested.

Parameters:
ADDR_WIDTH, 10, word-index width; array depth = 2**ADDR_WIDTH 32-bit words (4 KiB at default)
READ_LATENCY, 2, edges from request acceptance to completion for valid accesses; legal range 1..15
DATA_WIDTH, 32, data bus width; only 32 is supported

Ports:
clk  input  1  main clock, rising edge
reset  input  1  synchronous, active-high; returns the block to a known state
data_memory_a  input  32  byte address from the core
data_memory_read  input  1  read request; held by the core until mem_ready
data_memory_write  input  1  write request; held by the core until mem_ready
data_memory_out_v  input  32  write data from the core
data_memory_in_v  output  32  read data to the core
mem_ready  output  1  one-cycle completion pulse
mem_busy  output  1  high while a request is in flight (WAIT or RESP)
mem_error  output  1  high with mem_ready when the completed request was illegal

Behaviour:
- Reset (sampled at the clk edge, wins over everything): state=IDLE; data_memory_in_v=0, mem_ready=0, mem_busy=0, mem_error=0; latched address, data and kind are cleared; cnt=0.
  - Array contents are not cleared by reset. They are zero-initialised at simulation start.
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is accepted at an edge where data_memory_read|data_memory_write=1.
  - At acceptance the block latches the address, write data and kind.
  - After acceptance it ignores input changes until it returns to IDLE.
- Legality check at acceptance:
  - Illegal if both strobes are high.
  - Illegal if a[1:0]!=0 (misaligned).
  - Illegal if a[31:ADDR_WIDTH+2]!=0 (out of range; no aliasing).
- Illegal request: next state is RESP immediately (1-edge latency). No array write. In RESP, mem_error=1 and data_memory_in_v=0.
- Legal request: cnt loaded with READ_LATENCY-1.
  - If READ_LATENCY==1, next state is RESP.
  - Otherwise next state is WAIT.
- WAIT: if cnt==1, go to RESP; otherwise cnt decrements. Completion is therefore visible READ_LATENCY edges after the acceptance edge.
- Commit at the WAIT->RESP edge (or the IDLE->RESP edge when READ_LATENCY=1):
  - Write: mem[a[ADDR_WIDTH+1:2]] <= latched data.
  - Read: data_memory_in_v <= mem[index].
- RESP: mem_ready=1 for exactly one cycle, then IDLE on the next edge.
  - The core must drop the strobes in the cycle after mem_ready.
  - A strobe still high in IDLE is treated as a new request.
  - Maximum throughput is one access per READ_LATENCY+1 cycles.
- Output timing:
  - data_memory_in_v holds its last read value until the next read completion.
  - A write completion leaves data_memory_in_v unchanged.
  - An error completion forces data_memory_in_v to 0.
- mem_busy=1 in WAIT and RESP; 0 in IDLE.
- mem_error is only ever high together with mem_ready.
- Reset mid-operation (in WAIT): the request is abandoned and no write is committed. Reset in RESP: mem_ready drops on the reset edge.
- A read after a write to the same address returns the new data. Because the write commits before RESP, there is no hazard.

Test Plan:
1. Reset, READ_LATENCY=2. Write 0xDEADBEEF to 0x10 and hold until ready; then read 0x10. Required: mem_ready exactly 2 edges after each acceptance, data_memory_in_v=0xDEADBEEF, mem_error=0, mem_busy high for 2 cycles per access.
2. Read from misaligned 0x13. Required: mem_ready+mem_error on the cycle after the acceptance edge, data_memory_in_v=0. A subsequent read of 0x10 still returns 0xDEADBEEF.
3. With ADDR_WIDTH=10, write 0x12345678 to 0x1000 (out of range). Required: error, and a read of 0x0 returns 0 (no aliasing).
4. Assert read and write together at 0x20 with data 0xFFFFFFFF. Required: error; a later read of 0x20 returns 0.
5. Start a write of 0xAAAA5555 to 0x24, then assert reset in the first WAIT cycle. Required: all outputs 0 after the reset edge, and a read of 0x24 returns the old value 0.
6. Start a read of 0x10 and change data_memory_a to 0x24 during WAIT, then sweep READ_LATENCY=1 and 5. Required: the latched address is used (0xDEADBEEF returned), and ready arrives 1 and 5 edges after acceptance respectively.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Core <-> data-memory handshake bundle: byte address, strobes held until mem_ready, 32-bit data.
interface data_mem_responder_if;
   logic [31:0] data_memory_a;
   logic        data_memory_read;
   logic        data_memory_write;
   logic [31:0] data_memory_out_v;
   logic [31:0] data_memory_in_v;
   logic        mem_ready;
   logic        mem_busy;
   logic        mem_error;

   modport master (
      output data_memory_a, data_memory_read, data_memory_write, data_memory_out_v,
      input  data_memory_in_v, mem_ready, mem_busy, mem_error
   );
   modport slave (
      input  data_memory_a, data_memory_read, data_memory_write, data_memory_out_v,
      output data_memory_in_v, mem_ready, mem_busy, mem_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array behind an IDLE/WAIT/RESP handshake with READ_LATENCY wait states.
module data_mem_responder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 2,
   parameter int DATA_WIDTH   = 32
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    wr_q, err_q;
   logic [DATA_WIDTH-1:0]   in_v_q;
   logic                    accept, commit, use_in;
   logic                    req, legal;
   logic [ADDR_WIDTH-1:0]   bus_idx, c_idx;
   logic [DATA_WIDTH-1:0]   c_data;
   logic                    c_wr;

   // Zero at simulation start; contents deliberately survive reset.
   logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

   assign req     = bus.data_memory_read | bus.data_memory_write;
   assign bus_idx = bus.data_memory_a[ADDR_WIDTH+1:2];
   assign legal   = !(bus.data_memory_read && bus.data_memory_write)
                    && (bus.data_memory_a[1:0] == 2'b00)
                    && (bus.data_memory_a[31:ADDR_WIDTH+2] == '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      use_in    = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept = 1'b1;
            if (!legal) state_nxt = RESP;
            else begin
               cnt_nxt = 4'(READ_LATENCY - 1);
               if (READ_LATENCY == 1) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
                  use_in    = 1'b1;
               end else state_nxt = WAIT;
            end
         end
         WAIT: if (cnt == 4'd1) begin
            state_nxt = RESP;
            commit    = 1'b1;
         end else cnt_nxt = cnt - 4'd1;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Single-edge commits (READ_LATENCY==1) have no latched copy yet, so use the bus directly.
   assign c_idx  = use_in ? bus_idx : idx_q;
   assign c_data = use_in ? bus.data_memory_out_v : data_q;
   assign c_wr   = use_in ? bus.data_memory_write : wr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         idx_q  <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
         err_q  <= 1'b0;
         in_v_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            idx_q  <= bus_idx;
            data_q <= bus.data_memory_out_v;
            wr_q   <= bus.data_memory_write;
            err_q  <= !legal;
         end
         if (accept && !legal)   in_v_q <= '0;
         else if (commit && !c_wr) in_v_q <= mem[c_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && commit && c_wr) mem[c_idx] <= c_data;
   end

   assign bus.data_memory_in_v = in_v_q;
   assign bus.mem_ready        = (state == RESP);
   assign bus.mem_busy         = (state != IDLE);
   assign bus.mem_error        = (state == RESP) && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder at READ_LATENCY 2, 1 and 5.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   int          sel;
   logic [31:0] rdata;
   logic        ready, busy, err;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   data_mem_responder_if ifa ();
   data_mem_responder_if ifb ();
   data_mem_responder_if ifc ();

   assign ifa.data_memory_a = addr;  assign ifa.data_memory_out_v = wdata;
   assign ifb.data_memory_a = addr;  assign ifb.data_memory_out_v = wdata;
   assign ifc.data_memory_a = addr;  assign ifc.data_memory_out_v = wdata;
   assign ifa.data_memory_read = rd & (sel == 0);  assign ifa.data_memory_write = wr & (sel == 0);
   assign ifb.data_memory_read = rd & (sel == 1);  assign ifb.data_memory_write = wr & (sel == 1);
   assign ifc.data_memory_read = rd & (sel == 2);  assign ifc.data_memory_write = wr & (sel == 2);

   data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) dut_l2 (.clk(clk), .reset(rst), .bus(ifa));
   data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) dut_l1 (.clk(clk), .reset(rst), .bus(ifb));
   data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(5)) dut_l5 (.clk(clk), .reset(rst), .bus(ifc));

   always_comb begin
      rdata = ifa.data_memory_in_v; ready = ifa.mem_ready; busy = ifa.mem_busy; err = ifa.mem_error;
      if (sel == 1) begin
         rdata = ifb.data_memory_in_v; ready = ifb.mem_ready; busy = ifb.mem_busy; err = ifb.mem_error;
      end else if (sel == 2) begin
         rdata = ifc.data_memory_in_v; ready = ifc.mem_ready; busy = ifc.mem_busy; err = ifc.mem_error;
      end
   end

   typedef struct {
      int          dut;
      logic        r, w;
      logic [31:0] a, d;
      logic        chg;
      logic [31:0] alt;
      int          lat;
      logic        e;
      logic [31:0] q;
   } vec_t;

   vec_t vecs [15];
   localparam int N_PRE = 10;  // vectors before the reset-in-WAIT sequence

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      int n = 0;
      int bcnt = 0;
      @(negedge clk);
      sel = vecs[i].dut; rd = vecs[i].r; wr = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].d;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (busy) bcnt++;
         if (vecs[i].chg && n == 1) addr = vecs[i].alt;
         if (ready) break;
      end
      rd = 1'b0; wr = 1'b0;
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_error", i), {31'b0, err}, {31'b0, vecs[i].e});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].q);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_after", i), {30'b0, ready, busy}, 32'd0);
   endtask

   initial begin
      //            dut r     w     addr          data          chg   alt           lat e     rdata
      vecs[0]  = '{0, 1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        2, 1'b0, 32'h0};
      vecs[1]  = '{0, 1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'h0,        2, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{0, 1'b1, 1'b0, 32'h13,       32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0};
      vecs[3]  = '{0, 1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'h0,        2, 1'b0, 32'hDEADBEEF};
      vecs[4]  = '{0, 1'b0, 1'b1, 32'h1000,     32'h12345678, 1'b0, 32'h0,        1, 1'b1, 32'h0};
      vecs[5]  = '{0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        2, 1'b0, 32'h0};
      vecs[6]  = '{0, 1'b1, 1'b1, 32'h20,       32'hFFFFFFFF, 1'b0, 32'h0,        1, 1'b1, 32'h0};
      vecs[7]  = '{0, 1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'h0,        2, 1'b0, 32'h0};
      vecs[8]  = '{0, 1'b0, 1'b1, 32'hFFC,      32'hCAFEF00D, 1'b0, 32'h0,        2, 1'b0, 32'h0};
      vecs[9]  = '{0, 1'b1, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'h0,        2, 1'b0, 32'hCAFEF00D};
      vecs[10] = '{0, 1'b1, 1'b0, 32'h24,       32'h0,        1'b0, 32'h0,        2, 1'b0, 32'h0};
      vecs[11] = '{1, 1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1, 1'b0, 32'h0};
      vecs[12] = '{1, 1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h24,       1, 1'b0, 32'hDEADBEEF};
      vecs[13] = '{2, 1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        5, 1'b0, 32'h0};
      vecs[14] = '{2, 1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h24,       5, 1'b0, 32'hDEADBEEF};

      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         chk($sformatf("reset_outputs_dut%0d", s), {rdata[30:0], ready, busy, err}, 34'd0 >> 0);
         chk($sformatf("reset_rdata_dut%0d", s), rdata, 32'h0);
      end
      @(negedge clk); rst = 1'b0; sel = 0;

      for (int i = 0; i < N_PRE; i++) run_vec(i);

      // Write to 0x24 abandoned by a reset landing in its first WAIT cycle.
      @(negedge clk);
      sel = 0; wr = 1'b1; addr = 32'h24; wdata = 32'hAAAA5555;
      @(posedge clk); #1;
      chk("rst_wait_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1; wr = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait_flags", {29'b0, ready, busy, err}, 32'd0);
      chk("rst_wait_rdata", rdata, 32'h0);
      rst = 1'b0;

      for (int i = N_PRE; i < 15; i++) run_vec(i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
